// File: rtl/lut3_rr_sched.sv
// Round-robin scheduler sharing one reloadable 3-in/2-out lookup table among N_REQ requesters.
// Define LUT3_SCHED_STATS_EN to enable the saturating served-lookup counter on grant_cnt.
module lut3_rr_sched #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   in_code,
   output logic [N_REQ-1:0]     done,
   output logic [1:0]           out_data,
   output logic                 busy,
   input  logic                 cfg_we,
   input  logic [15:0]          cfg_data,
   output logic                 cfg_err,
   output logic [15:0]          grant_cnt
);

   localparam logic [15:0] DEFAULT_TABLE = 16'h0F37;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] winner_p0;
   logic [2:0]       code_p0;
   logic [1:0]       result_p1;
   logic [15:0]      lut;

   logic             found, hi_found;
   logic [PTR_W-1:0] hi_idx, lo_idx, pick;
   logic [2:0]       hi_code, lo_code, pick_code;

   // Two descending scans: lowest set bit at/above ptr wins, else lowest set bit overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      hi_code  = '0;
      lo_idx   = '0;
      lo_code  = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx  = PTR_W'(i);
            lo_code = in_code[3*i +: 3];
         end
         if (req[i] && (PTR_W'(i) >= ptr)) begin
            hi_found = 1'b1;
            hi_idx   = PTR_W'(i);
            hi_code  = in_code[3*i +: 3];
         end
      end
      found     = |req;
      pick      = hi_found ? hi_idx  : lo_idx;
      pick_code = hi_found ? hi_code : lo_code;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         lut     <= DEFAULT_TABLE;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cfg_err <= cfg_we && (state != IDLE);
         if (state == IDLE && cfg_we)
            lut <= cfg_data;
         if (state == RESP)
            ptr <= (winner_p0 == PTR_W'(N_REQ-1)) ? '0 : winner_p0 + PTR_W'(1);
      end
   end

   // Stage p0: capture winner and its code in IDLE; stage p1: table read in LOOKUP.
   always_ff @(posedge clk) begin
      if (state == IDLE && found) begin
         winner_p0 <= pick;
         code_p0   <= pick_code;
      end
      if (state == LOOKUP)
         result_p1 <= lut[{code_p0, 1'b0} +: 2];
   end

   always_comb begin
      busy     = (state != IDLE);
      out_data = (state == RESP) ? result_p1 : 2'b00;
      for (int i = 0; i < N_REQ; i++)
         done[i] = (state == RESP) && (winner_p0 == PTR_W'(i));
   end

`ifdef LUT3_SCHED_STATS_EN
   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= 16'h0000;
      else if (state == RESP && cnt != 16'hFFFF)
         cnt <= cnt + 16'h0001;
   end

   assign grant_cnt = cnt;
`else
   assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lut3_rr_sched.sv
// Bench for lut3_rr_sched: directed scenarios then randomized traffic against a queue-free reference model.
module tb_lut3_rr_sched;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] in_code;
   logic [3:0]  done;
   logic [1:0]  out_data;
   logic        busy;
   logic        cfg_we;
   logic [15:0] cfg_data;
   logic        cfg_err;
   logic [15:0] grant_cnt;

   int checks = 0;
   int errors = 0;

   logic [1:0] mtab [8];
   int         mptr;
   int         mgc;

   lut3_rr_sched #(.N_REQ(4), .PTR_W(3)) dut (
      .clk(clk), .rst(rst), .req(req), .in_code(in_code), .done(done),
      .out_data(out_data), .busy(busy), .cfg_we(cfg_we), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .grant_cnt(grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void default_tab();
      mtab = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
   endfunction

   function automatic void load_tab(input logic [15:0] t);
      for (int e = 0; e < 8; e++) mtab[e] = t[2*e +: 2];
   endfunction

   function automatic logic [31:0] exp_gc();
`ifdef LUT3_SCHED_STATS_EN
      return (mgc > 65535) ? 32'hFFFF : 32'(mgc);
`else
      return 32'h0;
`endif
   endfunction

   // Called at a negedge with the DUT in IDLE; leaves it at a negedge in IDLE.
   task automatic serve(input logic [3:0] mask, input logic [11:0] codes,
                        input bit we_i, input logic [15:0] tab_i,
                        input bit we_b, input logic [15:0] tab_b, input bit drop_early);
      int w;
      int idx;
      logic [1:0] wb;
      logic [2:0] c;
      logic [1:0] expv;
      req      = mask;
      in_code  = codes;
      cfg_we   = we_i;
      cfg_data = tab_i;
      if (we_i) load_tab(tab_i);
      w = 0;
      for (int k = N-1; k >= 0; k--) begin
         idx = (mptr + k) % N;
         if (mask[idx[1:0]]) w = idx;
      end
      wb   = w[1:0];
      c    = codes[3*w +: 3];
      expv = mtab[c];
      @(negedge clk);
      cfg_we   = we_b;
      cfg_data = tab_b;
      in_code  = 12'($urandom);
      if (drop_early) req[wb] = 1'b0;
      chk("lookup_done", 32'(done), 32'h0);
      chk("lookup_busy", 32'(busy), 32'h1);
      chk("lookup_err", 32'(cfg_err), 32'h0);
      @(negedge clk);
      cfg_we = 1'b0;
      chk("resp_done", 32'(done), 32'(1 << w));
      chk("resp_data", 32'(out_data), 32'(expv));
      chk("resp_err", 32'(cfg_err), 32'(we_b));
      chk("resp_busy", 32'(busy), 32'h1);
      req[wb] = 1'b0;
      mptr = (w + 1) % N;
      mgc++;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_data", 32'(out_data), 32'h0);
      chk("idle_err", 32'(cfg_err), 32'h0);
      chk("grant_cnt", 32'(grant_cnt), exp_gc());
   endtask

   initial begin
      logic [3:0] m;
      rst = 1'b1; req = '0; in_code = '0; cfg_we = 1'b0; cfg_data = '0;
      mptr = 0; mgc = 0;
      default_tab();
      repeat (2) @(negedge clk);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(cfg_err), 32'h0);
      chk("rst_gcnt", 32'(grant_cnt), 32'h0);
      rst = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("noreq_done", 32'(done), 32'h0);
         chk("noreq_busy", 32'(busy), 32'h0);
      end

      for (int k = 0; k < 8; k++)
         serve(4'b0001, {9'($urandom), 3'(k)}, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      m = 4'b1111;
      repeat (4) begin
         serve(m, 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
         m = req;
      end
      serve(4'b1111, 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      req = '0;

      serve(4'b1000, 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      serve(4'b0001, 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      serve(4'b1001, 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      req = '0;

      serve(4'b0001, 12'h003, 1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0);
      serve(4'b0001, 12'h003, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0);
      serve(4'b0001, 12'h003, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      req = 4'b0001; in_code = 12'h001;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_done", 32'(done), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_gcnt", 32'(grant_cnt), 32'h0);
      rst = 1'b0; req = '0;
      mptr = 0; mgc = 0;
      default_tab();
      serve(4'b0001, 12'h001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      repeat (4) serve(4'(1 << $urandom_range(0, 3)), 12'($urandom), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

      repeat (60) begin
         req = '0;
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            chk("gap_done", 32'(done), 32'h0);
            chk("gap_busy", 32'(busy), 32'h0);
         end
         serve(4'($urandom_range(1, 15)), 12'($urandom),
               ($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 1) == 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
